py_seq: RTL and testbench

PY_SEQ -- requirements
Module: py_seq

---
 rtl/py_seq_if.sv | 42 ++++
 rtl/py_seq.sv | 181 ++++++++++++++++++
 tb/tb_py_seq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/py_seq_if.sv
// Handshake and configuration bundle between the payload sequencer and its
// surrounding link controller / payload datapath.
interface py_seq_if;
  logic        seq_start_p;
  logic        seq_tx;
  logic [3:0]  pk_type;
  logic        packet_BRmode;
  logic [9:0]  regi_payloadlen;
  logic        hdr_endp;
  logic        py_datvalid_p;
  logic        py_endp;
  logic        dec_py_endp;
  logic        edrtailer_endp;
  logic        seq_abort;
  logic        py_st_p;
  logic [12:0] pylenbit;
  logic        crcencode;
  logic        fec31encode;
  logic        fec32encode;
  logic        pk_encode;
  logic        existpyheader;
  logic        BRss;
  logic        seq_busy;
  logic        seq_done_p;
  logic        seq_err_p;

  modport master (
    output seq_start_p, seq_tx, pk_type, packet_BRmode, regi_payloadlen,
           hdr_endp, py_datvalid_p, py_endp, dec_py_endp, edrtailer_endp,
           seq_abort,
    input  py_st_p, pylenbit, crcencode, fec31encode, fec32encode, pk_encode,
           existpyheader, BRss, seq_busy, seq_done_p, seq_err_p
  );

  modport slave (
    input  seq_start_p, seq_tx, pk_type, packet_BRmode, regi_payloadlen,
           hdr_endp, py_datvalid_p, py_endp, dec_py_endp, edrtailer_endp,
           seq_abort,
    output py_st_p, pylenbit, crcencode, fec31encode, fec32encode, pk_encode,
           existpyheader, BRss, seq_busy, seq_done_p, seq_err_p
  );
endinterface

// File: rtl/py_seq.sv
// Payload-phase sequencer: decodes packet type into datapath configuration,
// then walks header -> payload -> (EDR tail) -> done with a strobe watchdog.
module py_seq (
  input  logic     clk_6M,
  input  logic     rst,
  py_seq_if.slave  bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_HDR = 3'd1;
  localparam logic [2:0] ST_PAYLOAD  = 3'd2;
  localparam logic [2:0] ST_TAIL     = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  localparam logic [13:0] WDOG_LAST = 14'd11999;

  typedef struct packed {
    logic [12:0] bits;
    logic        crc;
    logic        fec32;
    logic        hdr;
    logic        brss;
  } cfg_t;

  function automatic logic [9:0] sat_len(input logic [9:0] len, input logic [9:0] lim);
    return (len > lim) ? lim : len;
  endfunction

  function automatic logic [12:0] len_bits(input logic [4:0] hdr_bits, input logic [9:0] nbytes);
    return 13'(hdr_bits) + {nbytes, 3'b000};
  endfunction

  // Basic-rate and EDR variants differ in header width, byte limit and FEC.
  function automatic cfg_t decode_cfg(input logic [3:0] typ, input logic br, input logic [9:0] len);
    cfg_t c;
    c = '0;
    case (typ)
      4'h2: begin
        c.bits = 13'd144; c.crc = 1'b1; c.fec32 = 1'b1; c.brss = 1'b1;
      end
      4'h3: begin
        c.bits = len_bits(5'd8, sat_len(len, 10'd17));
        c.crc = 1'b1; c.fec32 = 1'b1; c.hdr = 1'b1; c.brss = 1'b1;
      end
      4'h4: begin
        c.bits = br ? len_bits(5'd8, sat_len(len, 10'd27)) : len_bits(5'd16, sat_len(len, 10'd54));
        c.crc = 1'b1; c.hdr = 1'b1; c.brss = 1'b1;
      end
      4'hA: begin
        c.bits = len_bits(5'd16, sat_len(len, br ? 10'd121 : 10'd367));
        c.crc = 1'b1; c.fec32 = br; c.hdr = 1'b1;
      end
      4'hB: begin
        c.bits = len_bits(5'd16, sat_len(len, br ? 10'd183 : 10'd552));
        c.crc = 1'b1; c.hdr = 1'b1;
      end
      4'hE: begin
        c.bits = len_bits(5'd16, sat_len(len, br ? 10'd224 : 10'd679));
        c.crc = 1'b1; c.fec32 = br; c.hdr = 1'b1;
      end
      4'hF: begin
        c.bits = len_bits(5'd16, sat_len(len, br ? 10'd339 : 10'd1021));
        c.crc = 1'b1; c.hdr = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  logic [2:0]  state;
  logic [13:0] wdog;
  logic        tx_q;
  logic        br_q;
  logic [3:0]  type_q;
  logic [9:0]  len_q;
  logic        py_st_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  cfg_t cfg;
  logic active;
  logic wdog_hit;
  logic pay_end;

  // Configuration is a pure function of the latched fields, so it holds
  // until the next accepted start and clears with them on reset.
  assign cfg      = decode_cfg(type_q, br_q, len_q);
  assign active   = (state == ST_WAIT_HDR) || (state == ST_PAYLOAD) || (state == ST_TAIL);
  assign wdog_hit = active && bus.py_datvalid_p && (wdog == WDOG_LAST);
  assign pay_end  = bus.py_datvalid_p && (tx_q ? bus.py_endp : bus.dec_py_endp);

  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      wdog    <= '0;
      tx_q    <= 1'b0;
      br_q    <= 1'b0;
      type_q  <= '0;
      len_q   <= '0;
      py_st_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      py_st_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (state == ST_IDLE) begin
        if (bus.seq_start_p) begin
          tx_q   <= bus.seq_tx;
          br_q   <= bus.packet_BRmode;
          type_q <= bus.pk_type;
          len_q  <= bus.regi_payloadlen;
          wdog   <= '0;
          busy_q <= 1'b1;
          state  <= ST_WAIT_HDR;
        end
      end else if (bus.seq_abort || wdog_hit) begin
        // Abort and timeout outrank any completion event in the same cycle.
        state  <= ST_IDLE;
        busy_q <= 1'b0;
        err_q  <= 1'b1;
      end else begin
        case (state)
          ST_WAIT_HDR: begin
            if (bus.hdr_endp) begin
              if (cfg.bits == 13'd0) begin
                state  <= ST_DONE;
                done_q <= 1'b1;
              end else begin
                state   <= ST_PAYLOAD;
                py_st_q <= 1'b1;
                wdog    <= '0;
              end
            end else if (bus.py_datvalid_p) begin
              wdog <= wdog + 14'd1;
            end
          end
          ST_PAYLOAD: begin
            if (pay_end) begin
              if (tx_q && !br_q) begin
                state <= ST_TAIL;
              end else begin
                state  <= ST_DONE;
                done_q <= 1'b1;
              end
            end else if (bus.py_datvalid_p) begin
              wdog <= wdog + 14'd1;
            end
          end
          ST_TAIL: begin
            if (bus.edrtailer_endp) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else if (bus.py_datvalid_p) begin
              wdog <= wdog + 14'd1;
            end
          end
          default: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.py_st_p       = py_st_q;
  assign bus.pylenbit      = cfg.bits;
  assign bus.crcencode     = cfg.crc;
  assign bus.fec31encode   = 1'b0;
  assign bus.fec32encode   = cfg.fec32;
  assign bus.pk_encode     = tx_q;
  assign bus.existpyheader = cfg.hdr;
  assign bus.BRss          = cfg.brss;
  assign bus.seq_busy      = busy_q;
  assign bus.seq_done_p    = done_q;
  assign bus.seq_err_p     = err_q;

endmodule

// File: tb/tb_py_seq.sv
// Directed bench for py_seq: type decode, phase sequencing, abort, watchdog, reset.
module tb_py_seq;

  logic clk_6M = 1'b0;
  logic rst    = 1'b1;
  int   n_chk  = 0;
  int   n_bad  = 0;

  py_seq_if bus();

  py_seq dut (
    .clk_6M (clk_6M),
    .rst    (rst),
    .bus    (bus)
  );

  always #83 clk_6M = ~clk_6M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic clr_in();
    bus.seq_start_p     = 1'b0;
    bus.hdr_endp        = 1'b0;
    bus.py_datvalid_p   = 1'b0;
    bus.py_endp         = 1'b0;
    bus.dec_py_endp     = 1'b0;
    bus.edrtailer_endp  = 1'b0;
    bus.seq_abort       = 1'b0;
  endtask

  task automatic start(input logic tx, input logic [3:0] typ, input logic br, input logic [9:0] len);
    bus.seq_start_p     = 1'b1;
    bus.seq_tx          = tx;
    bus.pk_type         = typ;
    bus.packet_BRmode   = br;
    bus.regi_payloadlen = len;
    tick();
    bus.seq_start_p     = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  typ;
    logic        br;
    logic [9:0]  len;
    logic [12:0] bits;
    logic        fec;
  } vec_t;

  vec_t vecs [7];
  int   cnt;

  initial begin
    vecs[0] = '{4'h3, 1'b0, 10'd20,  13'd144,  1'b1};
    vecs[1] = '{4'hA, 1'b1, 10'd100, 13'd816,  1'b1};
    vecs[2] = '{4'hA, 1'b0, 10'd400, 13'd2952, 1'b0};
    vecs[3] = '{4'hB, 1'b1, 10'd0,   13'd16,   1'b0};
    vecs[4] = '{4'hE, 1'b0, 10'd700, 13'd5448, 1'b0};
    vecs[5] = '{4'h4, 1'b0, 10'd60,  13'd448,  1'b0};
    vecs[6] = '{4'h7, 1'b1, 10'd50,  13'd0,    1'b0};

    clr_in();
    bus.seq_tx = 1'b0; bus.pk_type = '0; bus.packet_BRmode = 1'b0; bus.regi_payloadlen = '0;
    tick(); tick();
    chk("rst_busy", bus.seq_busy, 0);
    chk("rst_len", bus.pylenbit, 0);
    chk("rst_crc", bus.crcencode, 0);
    chk("rst_done", bus.seq_done_p, 0);
    chk("rst_err", bus.seq_err_p, 0);
    chk("rst_st", bus.py_st_p, 0);

    // BR tx DH1, len 40; start on first edge after reset release
    rst = 1'b0;
    start(1'b1, 4'h4, 1'b1, 10'd40);
    chk("dh1_busy", bus.seq_busy, 1);
    chk("dh1_len", bus.pylenbit, 224);
    chk("dh1_crc", bus.crcencode, 1);
    chk("dh1_fec32", bus.fec32encode, 0);
    chk("dh1_fec31", bus.fec31encode, 0);
    chk("dh1_hdr", bus.existpyheader, 1);
    chk("dh1_brss", bus.BRss, 1);
    chk("dh1_enc", bus.pk_encode, 1);
    bus.hdr_endp = 1'b1; tick(); bus.hdr_endp = 1'b0;
    chk("dh1_st", bus.py_st_p, 1);
    start(1'b0, 4'h2, 1'b1, 10'd5);
    chk("dh1_st_once", bus.py_st_p, 0);
    chk("dh1_ign_start", bus.pylenbit, 224);
    bus.py_endp = 1'b1; bus.py_datvalid_p = 1'b1; tick(); clr_in();
    chk("dh1_done", bus.seq_done_p, 1);
    chk("dh1_busy_done", bus.seq_busy, 1);
    tick();
    chk("dh1_done_off", bus.seq_done_p, 0);
    chk("dh1_idle", bus.seq_busy, 0);

    // FHS rx: py_endp must not complete, dec_py_endp does
    start(1'b0, 4'h2, 1'b1, 10'd5);
    chk("fhs_len", bus.pylenbit, 144);
    chk("fhs_fec32", bus.fec32encode, 1);
    chk("fhs_enc", bus.pk_encode, 0);
    chk("fhs_hdr", bus.existpyheader, 0);
    bus.hdr_endp = 1'b1; tick(); bus.hdr_endp = 1'b0;
    chk("fhs_st", bus.py_st_p, 1);
    bus.py_endp = 1'b1; bus.py_datvalid_p = 1'b1; tick(); clr_in();
    chk("fhs_txend_ign", bus.seq_done_p, 0);
    bus.dec_py_endp = 1'b1; bus.py_datvalid_p = 1'b1; tick(); clr_in();
    chk("fhs_done", bus.seq_done_p, 1);
    tick();

    // EDR tx DH5, len 1023 -> tail phase
    start(1'b1, 4'hF, 1'b0, 10'd1023);
    chk("dh5_len", bus.pylenbit, 8184);
    chk("dh5_brss", bus.BRss, 0);
    chk("dh5_fec32", bus.fec32encode, 0);
    bus.hdr_endp = 1'b1; tick(); bus.hdr_endp = 1'b0;
    bus.py_endp = 1'b1; bus.py_datvalid_p = 1'b1; tick(); clr_in();
    chk("dh5_tail_nodone", bus.seq_done_p, 0);
    tick();
    chk("dh5_tail_wait", bus.seq_done_p, 0);
    chk("dh5_tail_busy", bus.seq_busy, 1);
    bus.edrtailer_endp = 1'b1; tick(); clr_in();
    chk("dh5_done", bus.seq_done_p, 1);
    tick();

    // NULL: straight to done, no payload start
    start(1'b1, 4'h0, 1'b1, 10'd9);
    chk("null_len", bus.pylenbit, 0);
    bus.hdr_endp = 1'b1; tick(); bus.hdr_endp = 1'b0;
    chk("null_st", bus.py_st_p, 0);
    chk("null_done", bus.seq_done_p, 1);
    tick();
    chk("null_idle", bus.seq_busy, 0);

    // Decode table; each phase cancelled with abort
    for (int i = 0; i < 7; i++) begin
      start(1'b1, vecs[i].typ, vecs[i].br, vecs[i].len);
      chk($sformatf("vec%0d_len", i), bus.pylenbit, vecs[i].bits);
      chk($sformatf("vec%0d_fec", i), bus.fec32encode, vecs[i].fec);
      bus.seq_abort = 1'b1; tick(); clr_in();
      chk($sformatf("vec%0d_err", i), bus.seq_err_p, 1);
    end
    tick();

    // Abort coincident with payload end
    start(1'b1, 4'h3, 1'b1, 10'd30);
    chk("dm1_len", bus.pylenbit, 144);
    bus.hdr_endp = 1'b1; tick(); bus.hdr_endp = 1'b0;
    bus.py_endp = 1'b1; bus.py_datvalid_p = 1'b1; bus.seq_abort = 1'b1; tick(); clr_in();
    chk("abt_err", bus.seq_err_p, 1);
    chk("abt_done", bus.seq_done_p, 0);
    chk("abt_busy", bus.seq_busy, 0);
    chk("abt_hold", bus.pylenbit, 144);
    tick();
    chk("abt_done2", bus.seq_done_p, 0);
    chk("abt_err_off", bus.seq_err_p, 0);

    // Abort coincident with header end
    start(1'b1, 4'h4, 1'b1, 10'd10);
    bus.hdr_endp = 1'b1; bus.seq_abort = 1'b1; tick(); clr_in();
    chk("abth_st", bus.py_st_p, 0);
    chk("abth_err", bus.seq_err_p, 1);
    tick();
    chk("abth_st2", bus.py_st_p, 0);

    // Watchdog: header never arrives
    start(1'b1, 4'h4, 1'b1, 10'd10);
    bus.py_datvalid_p = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 13000; i++) begin
      tick();
      if (bus.seq_err_p === 1'b1) begin
        cnt = i;
        break;
      end
    end
    clr_in();
    chk("wdog_strobes", cnt, 12000);
    chk("wdog_busy", bus.seq_busy, 0);
    chk("wdog_done", bus.seq_done_p, 0);
    tick();

    // Asynchronous reset in the middle of a payload
    start(1'b1, 4'hB, 1'b1, 10'd200);
    chk("dh3_len", bus.pylenbit, 1480);
    bus.hdr_endp = 1'b1; tick(); bus.hdr_endp = 1'b0;
    chk("dh3_st", bus.py_st_p, 1);
    #20 rst = 1'b1;
    #1;
    chk("arst_busy", bus.seq_busy, 0);
    chk("arst_len", bus.pylenbit, 0);
    chk("arst_crc", bus.crcencode, 0);
    chk("arst_enc", bus.pk_encode, 0);
    chk("arst_st", bus.py_st_p, 0);
    chk("arst_hdr", bus.existpyheader, 0);
    tick();
    rst = 1'b0;
    start(1'b0, 4'h2, 1'b1, 10'd0);
    chk("post_rst_busy", bus.seq_busy, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
